// File: rtl/led_arbiter.sv
`timescale 1ns/1ps
// led_arbiter: three-way round-robin arbiter handing the user LEDs to one requester at a time,
// with hold-time preemption. Define LED_ARB_PWM_EN to gate LEDs with an 8-bit DUTY brightness PWM.
module led_arbiter #(
    parameter int HOLD_MAX = 12000000,
    parameter int HOLD_W   = 24
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] REQ,
    input  logic [4:0] PAT0,
    input  logic [4:0] PAT1,
    input  logic [4:0] PAT2,
    input  logic [7:0] DUTY,
    output logic [2:0] GNT,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic       LED4,
    output logic       LED5,
    output logic       LEDG_N,
    output logic       LEDR_N
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [4:0]        led_q, led_d;
    logic              ledg_n_q, ledg_n_d;
    logic              ledr_n_q, ledr_n_d;

    logic [1:0]        cand1, cand2, pick;
    logic [2:0]        owner_oh;
    logic [4:0]        pat_sel;
    logic              led_gate;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [2:0] to_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // owner_q doubles as last_owner: it holds the previous owner through GAP and IDLE.
    always_comb begin
        cand1 = next_idx(owner_q);
        cand2 = next_idx(cand1);
        if (REQ[cand1]) begin
            pick = cand1;
        end else if (REQ[cand2]) begin
            pick = cand2;
        end else begin
            pick = owner_q;
        end
    end

    always_comb begin
        owner_oh = to_onehot(owner_q);
        case (owner_q)
            2'd0:    pat_sel = PAT0;
            2'd1:    pat_sel = PAT1;
            default: pat_sel = PAT2;
        endcase
    end

`ifdef LED_ARB_PWM_EN
    logic [7:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d    = pwm_q + 8'd1;
        led_gate = (pwm_q < DUTY);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`else
    logic unused_duty;

    always_comb begin
        led_gate    = 1'b1;
        unused_duty = ^DUTY;
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (|REQ) begin
                    state_d = ST_GRANT;
                    owner_d = pick;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                // Owner release wins over preemption; a lone owner keeps the grant once saturated.
                if (!REQ[owner_q]) begin
                    state_d = ST_GAP;
                end else if ((hold_q == HOLD_LAST) && (|(REQ & ~owner_oh))) begin
                    state_d = ST_GAP;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // LEDs lag the grant by one cycle and are dark on the cycle that leaves GRANT.
    always_comb begin
        gnt_d    = (state_d == ST_GRANT) ? to_onehot(owner_d) : 3'b000;
        led_d    = ((state_q == ST_GRANT) && (state_d == ST_GRANT)) ? (pat_sel & {5{led_gate}}) : '0;
        ledg_n_d = (state_d != ST_GRANT);
        ledr_n_d = ~|(REQ & ~gnt_d);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            owner_q  <= 2'd2;
            hold_q   <= '0;
            gnt_q    <= '0;
            led_q    <= '0;
            ledg_n_q <= 1'b1;
            ledr_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            gnt_q    <= gnt_d;
            led_q    <= led_d;
            ledg_n_q <= ledg_n_d;
            ledr_n_q <= ledr_n_d;
        end
    end

    assign GNT    = gnt_q;
    assign LED1   = led_q[0];
    assign LED2   = led_q[1];
    assign LED3   = led_q[2];
    assign LED4   = led_q[3];
    assign LED5   = led_q[4];
    assign LEDG_N = ledg_n_q;
    assign LEDR_N = ledr_n_q;

endmodule

// File: tb/tb_led_arbiter.sv
`timescale 1ns/1ps
// Bench for led_arbiter (HOLD_MAX=8): directed scenarios plus random request traffic,
// all compared against a cycle-level ownership model kept here.
module tb_led_arbiter;

    localparam int HOLD_MAX = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic [2:0] REQ = '0;
    logic [4:0] PAT0 = '0;
    logic [4:0] PAT1 = '0;
    logic [4:0] PAT2 = '0;
    logic [7:0] DUTY = '0;
    logic [2:0] GNT;
    logic       LED1, LED2, LED3, LED4, LED5;
    logic       LEDG_N, LEDR_N;
    logic [4:0] leds;

    assign leds = {LED5, LED4, LED3, LED2, LED1};

    led_arbiter #(
        .HOLD_MAX(HOLD_MAX),
        .HOLD_W  (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .PAT0  (PAT0),
        .PAT1  (PAT1),
        .PAT2  (PAT2),
        .DUTY  (DUTY),
        .GNT   (GNT),
        .LED1  (LED1),
        .LED2  (LED2),
        .LED3  (LED3),
        .LED4  (LED4),
        .LED5  (LED5),
        .LEDG_N(LEDG_N),
        .LEDR_N(LEDR_N)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the LEDs, for how many cycles, and a pending one-cycle gap.
    int         m_owner;
    int         m_last;
    int         m_held;
    int         m_gap;
    int         m_pwm;
    logic [2:0] m_gnt;
    logic [4:0] m_led;
    logic       m_ledg_n;
    logic       m_ledr_n;

    function automatic logic [2:0] onehot_of(input int i);
        case (i)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [4:0] pat_of(input int i);
        case (i)
            0:       return PAT0;
            1:       return PAT1;
            default: return PAT2;
        endcase
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_last   = 2;
        m_held   = 0;
        m_gap    = 0;
        m_pwm    = 0;
        m_gnt    = 3'b000;
        m_led    = 5'b00000;
        m_ledg_n = 1'b1;
        m_ledr_n = 1'b1;
    endtask

    task automatic model_edge();
        int         prev;
        logic [4:0] pat_now;
        logic       gate;
        prev    = m_owner;
        pat_now = (prev >= 0) ? pat_of(prev) : 5'b00000;
`ifdef LED_ARB_PWM_EN
        gate  = (m_pwm < int'(DUTY));
        m_pwm = (m_pwm + 1) % 256;
`else
        gate = 1'b1;
`endif
        if (m_owner >= 0) begin
            if (!REQ[m_owner] || (m_held >= HOLD_MAX && (REQ & ~onehot_of(m_owner)) != 3'b000)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else if (REQ != 3'b000) begin
            for (int k = 1; k <= 3; k++) begin
                if (m_owner < 0 && REQ[(m_last + k) % 3]) m_owner = (m_last + k) % 3;
            end
            m_held = 1;
        end
        m_gnt    = (m_owner >= 0) ? onehot_of(m_owner) : 3'b000;
        m_led    = (prev >= 0 && m_owner >= 0 && gate) ? pat_now : 5'b00000;
        m_ledg_n = (m_owner < 0);
        m_ledr_n = ((REQ & ~m_gnt) == 3'b000);
    endtask

    task automatic compare_all();
        check("gnt",    32'(GNT),    32'(m_gnt));
        check("led",    32'(leds),   32'(m_led));
        check("ledg_n", 32'(LEDG_N), 32'(m_ledg_n));
        check("ledr_n", 32'(LEDR_N), 32'(m_ledr_n));
    endtask

    // One clock: model advances on the same edge the DUT samples; outputs read on the falling edge.
    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        compare_all();
    endtask

    // Entered at a falling edge; reset asserts between edges and must act without a clock.
    task automatic apply_reset();
        #2 RST_N = 1'b0;
        #1;
        check("rst_gnt",    32'(GNT),    32'h0);
        check("rst_led",    32'(leds),   32'h0);
        check("rst_ledg_n", 32'(LEDG_N), 32'h1);
        check("rst_ledr_n", 32'(LEDR_N), 32'h1);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int on_cnt;
        model_reset();
        apply_reset();

        // First grant from reset goes to requester 0; LEDs follow one cycle later.
        REQ  = 3'b001;
        PAT0 = 5'b10101;
        DUTY = 8'd255;
        step();
        check("first_gnt", 32'(GNT), 32'h1);
        step();
`ifndef LED_ARB_PWM_EN
        check("first_led", 32'(leds), 32'h15);
`endif
        check("first_ledg_n", 32'(LEDG_N), 32'h0);
        check("first_ledr_n", 32'(LEDR_N), 32'h1);

        // All three held: 8 grant cycles each, two dark cycles between, rotating 0,1,2,0...
        apply_reset();
        REQ  = 3'b111;
        PAT0 = 5'(($urandom));
        PAT1 = 5'(($urandom));
        PAT2 = 5'(($urandom));
        for (int i = 1; i <= 60; i++) begin
            step();
            check("rot_gnt", 32'(GNT),
                  32'((((i - 1) % 10) < 8) ? onehot_of(((i - 1) / 10) % 3) : 3'b000));
            check("rot_ledr_n", 32'(LEDR_N), 32'h0);
        end

        // A lone requester keeps the grant past saturation.
        apply_reset();
        REQ = 3'b010;
        for (int i = 0; i < 100; i++) begin
            step();
            check("solo_gnt", 32'(GNT), 32'h2);
        end

        // Owner drops early; idle requester 1 is skipped and 2 wins after GAP and IDLE.
        apply_reset();
        REQ = 3'b101;
        for (int i = 0; i < 3; i++) begin
            step();
            check("drop_hold_gnt", 32'(GNT), 32'h1);
        end
        REQ = 3'b100;
        step();
        check("drop_gap_gnt", 32'(GNT), 32'h0);
        step();
        check("drop_idle_gnt", 32'(GNT), 32'h0);
        step();
        check("drop_next_gnt", 32'(GNT), 32'h4);

        // A request pulse between edges is never seen; a sampled one gets exactly one grant cycle.
        apply_reset();
        REQ = 3'b001;
        #2 REQ = 3'b000;
        step();
        check("blip_gnt", 32'(GNT), 32'h0);
        REQ = 3'b010;
        step();
        check("short_gnt", 32'(GNT), 32'h2);
        REQ = 3'b000;
        step();
        check("short_gap_gnt", 32'(GNT), 32'h0);
        step();

        // Reset while a grant is live with a waiting requester.
        apply_reset();
        REQ  = 3'b011;
        PAT0 = 5'b11111;
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_ledr_n", 32'(LEDR_N), 32'h0);
        apply_reset();

        // Brightness: count lit cycles over one full PWM period.
        REQ  = 3'b001;
        PAT0 = 5'b11111;
        DUTY = 8'd64;
        step();
        step();
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (leds == 5'b11111) on_cnt++;
        end
`ifdef LED_ARB_PWM_EN
        check("pwm64_on", 32'(on_cnt), 32'd64);
`else
        check("nopwm_on", 32'(on_cnt), 32'd256);
`endif
        DUTY   = 8'd0;
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (leds != 5'b00000) on_cnt++;
        end
`ifdef LED_ARB_PWM_EN
        check("pwm0_on", 32'(on_cnt), 32'd0);
`else
        check("nopwm_duty0_on", 32'(on_cnt), 32'd256);
`endif

        // Random traffic: sticky request bits with occasional flips, pattern/duty changes, resets.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(7) == 0) REQ[b] = ~REQ[b];
            end
            if ($urandom_range(15) == 0) begin
                PAT0 = 5'($urandom);
                PAT1 = 5'($urandom);
                PAT2 = 5'($urandom);
            end
            if ($urandom_range(63) == 0) DUTY = 8'($urandom);
            if ($urandom_range(499) == 0) apply_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 12000000: maximum grant cycles (1 s at 12 MHz) before preemption when another requester waits.
REQ-002 Parameter HOLD_W, default 24: hold-counter width; HOLD_MAX SHALL fit in HOLD_W bits and be >= 2.
REQ-003 CLK  in  1  12 MHz system clock, all state on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 REQ  in  3  request per requester, level-held; bit i = requester i.
REQ-006 PAT0, PAT1, PAT2  in  5 each  LED pattern of requester 0/1/2, bit k drives LED(k+1).
REQ-007 DUTY  in  8  brightness duty, used only per REQ-025.
REQ-008 GNT  out  3  one-hot grant, all-zero when no owner.
REQ-009 LED1..LED5  out  1 each  active-high user LEDs.
REQ-010 LEDG_N  out  1  active-low green: low while any grant is active.
REQ-011 LEDR_N  out  1  active-low red: low while at least one requester is asserted and not granted.

Function
REQ-012 FSM states IDLE, GRANT, GAP; all outputs registered.
REQ-013 IDLE: GNT=0, LEDs=0; if REQ != 0 at edge t, SHALL enter GRANT with GNT one-hot visible at t+1.
REQ-014 Selection round-robin: search order starts at (last_owner+1) mod 3 and wraps; last_owner resets to 2, so requester 0 wins first from reset.
REQ-015 GRANT: LED(k+1) at t+1 = PAT<owner>[k] at t; PAT changes during grant follow with one-cycle latency.
REQ-016 Hold counter clears on GRANT entry, increments each GRANT cycle, saturates at HOLD_MAX-1, never wraps.
REQ-017 GRANT -> GAP when owner's REQ bit is 0, or when counter == HOLD_MAX-1 and any other REQ bit is 1; owner drop takes priority when both occur.
REQ-018 Counter saturated with no other requester: owner keeps grant indefinitely.
REQ-019 GAP lasts exactly one cycle: GNT=0, LEDs=0, last_owner=previous owner; then IDLE unconditionally.
REQ-020 Worst-case handover: old GNT falls at t+1, new GNT rises at t+3.
REQ-021 LEDG_N = ~(state==GRANT), registered; LEDR_N = ~|(REQ & ~GNT_next), registered.
REQ-022 REQ asserted and released within the same IDLE cycle with no edge sampling it SHALL produce no grant; a request sampled in IDLE gets at least one GRANT cycle even if dropped immediately.

Reset
REQ-023 RST_N low asynchronously forces state=IDLE, GNT=0, LED1..LED5=0, LEDG_N=1, LEDR_N=1, counter=0, last_owner=2, PWM counter=0, including mid-grant.
REQ-024 After RST_N rises, first arbitration occurs on the first rising edge that samples RST_N high.

Configuration
REQ-025 Macro LED_ARB_PWM_EN defined: free-running 8-bit PWM counter; LED(k+1) = pattern bit AND (pwm_cnt < DUTY); DUTY=0 gives all off, DUTY=255 gives on 255/256 cycles.
REQ-026 LED_ARB_PWM_EN undefined: DUTY ignored, no PWM counter, LEDs equal pattern bits directly; port list unchanged.

Verification (sim with HOLD_MAX=8, HOLD_W=4)
REQ-027 Reset, REQ=3'b001, PAT0=5'b10101 -> GNT=001 at t+1, LED5..1=10101 at t+2, LEDG_N=0, LEDR_N=1.
REQ-028 REQ=3'b111 held -> grants rotate 001,010,100,001, each 8 GRANT cycles, 2 zero-grant cycles between, LEDR_N=0 throughout.
REQ-029 REQ=3'b010 alone held 100 cycles -> GNT=010 for all 100 cycles, no GAP entered.
REQ-030 Owner 0 drops REQ on grant cycle 3 while REQ[2]=1 -> GAP, IDLE, then GNT=100 (requester 1 idle skipped by wrap).
REQ-031 RST_N pulsed low mid-grant between edges -> all outputs at reset values immediately, before next CLK edge.
REQ-032 LED_ARB_PWM_EN defined, DUTY=64, PAT0=5'b11111 -> each LED high exactly 64 of every 256 cycles; DUTY=0 -> LEDs constant 0.
